request_unit_rr: RTL and testbench

Parametrised multi-channel request unit between the datapath memory stages and the single memory-controller port. Each of NCH channels posts a read or write. The unit latches it until serviced, arbitrates round-robin onto one memory port, and returns a one-cycle hit with read data. It adds sticky per-channel halt and a bus-timeout abort, which the single-channel request unit lacks.

---
 rtl/request_unit_rr.sv | 184 ++++++++++++++++++
 tb/tb_request_unit_rr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/request_unit_rr.sv
// request_unit_rr: NCH-channel request unit arbitrating round-robin onto one
// memory port, with sticky per-channel halt and a BUSY-cycle timeout abort.

module request_unit_rr_slot #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ren,
  input  logic          wen,
  input  logic          halt,
  input  logic          clr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          pending,
  output logic          halted,
  output logic          isWr,
  output logic [AW-1:0] slotAddr,
  output logic [DW-1:0] slotWdata
);
  logic take;

  // a halt arriving with the request wins, so the request is dropped
  assign take = (ren | wen) & ~pending & ~halted & ~halt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending   <= 1'b0;
      halted    <= 1'b0;
      isWr      <= 1'b0;
      slotAddr  <= '0;
      slotWdata <= '0;
    end else begin
      if (halt) halted <= 1'b1;
      if (take) begin
        pending   <= 1'b1;
        isWr      <= wen;
        slotAddr  <= addr;
        slotWdata <= wdata;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

module request_unit_rr #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    ch_ren,
  input  logic [NCH-1:0]    ch_wen,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH-1:0]    ch_halt,
  output logic [NCH-1:0]    ch_busy,
  output logic [NCH-1:0]    ch_hit,
  output logic [NCH-1:0]    ch_err,
  output logic [DW-1:0]     ch_rdata,
  output logic [NCH-1:0]    ch_halted,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_hit,
  input  logic [DW-1:0]     mem_rdata,
  output logic              tmo_flag
);
  localparam int LGW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TMO > 0) ? CW'(TMO - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, nextState;

  logic [NCH-1:0]         pending, halted, isWr, retire;
  logic [NCH-1:0][AW-1:0] slotAddr;
  logic [NCH-1:0][DW-1:0] slotWdata;
  logic [LGW-1:0]         lastGrant, gnt, rrIdx;
  logic [CW-1:0]          count;
  logic                   anyPend, tmoHit, doGrant, doHit, doErr;

  for (genvar i = 0; i < NCH; i++) begin : gSlot
    request_unit_rr_slot #(.AW(AW), .DW(DW)) uSlot (
      .CLK      (CLK),
      .RST      (RST),
      .ren      (ch_ren[i]),
      .wen      (ch_wen[i]),
      .halt     (ch_halt[i]),
      .clr      (retire[i]),
      .addr     (ch_addr[i*AW +: AW]),
      .wdata    (ch_wdata[i*DW +: DW]),
      .pending  (pending[i]),
      .halted   (halted[i]),
      .isWr     (isWr[i]),
      .slotAddr (slotAddr[i]),
      .slotWdata(slotWdata[i])
    );
  end

  assign ch_busy   = pending;
  assign ch_halted = halted;
  assign anyPend   = |pending;
  assign tmoHit    = (TMO != 0) && (count == CNT_LAST);

  // descending scan: the last match is the nearest channel after lastGrant
  always_comb begin
    int idx;
    idx   = 0;
    rrIdx = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(lastGrant) + k) % NCH;
      if (pending[idx]) rrIdx = LGW'(idx);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (anyPend) nextState = BUSY;
      BUSY: if (mem_hit || tmoHit) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    doGrant = (state == IDLE) && anyPend;
    doHit   = (state == BUSY) && mem_hit;
    doErr   = (state == BUSY) && !mem_hit && tmoHit;
    retire  = '0;
    if (doHit || doErr) retire[gnt] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lastGrant <= LGW'(NCH - 1);
      gnt       <= '0;
      count     <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ch_hit    <= '0;
      ch_err    <= '0;
      ch_rdata  <= '0;
      tmo_flag  <= 1'b0;
    end else begin
      ch_hit   <= '0;
      ch_err   <= '0;
      ch_rdata <= '0;
      if (doGrant) begin
        gnt       <= rrIdx;
        lastGrant <= rrIdx;
        count     <= '0;
        mem_ren   <= ~isWr[rrIdx];
        mem_wen   <= isWr[rrIdx];
        mem_addr  <= slotAddr[rrIdx];
        mem_wdata <= slotWdata[rrIdx];
      end else if (doHit) begin
        ch_hit[gnt] <= 1'b1;
        ch_rdata    <= mem_wen ? '0 : mem_rdata;
        mem_ren     <= 1'b0;
        mem_wen     <= 1'b0;
      end else if (doErr) begin
        ch_err[gnt] <= 1'b1;
        tmo_flag    <= 1'b1;
        mem_ren     <= 1'b0;
        mem_wen     <= 1'b0;
      end else if (state == BUSY && count != '1) begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_request_unit_rr.sv
// Directed bench for request_unit_rr (NCH=2, TMO=4): per-cycle vector table
// for arbitration, then hand sequences for timeout, reset, pending and halt.

module tb_request_unit_rr;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [1:0]  ch_ren, ch_wen, ch_halt;
  logic [63:0] ch_addr, ch_wdata;
  logic [1:0]  ch_busy, ch_hit, ch_err, ch_halted;
  logic [31:0] ch_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen, mem_hit, tmo_flag;
  int          checks = 0, failures = 0;

  request_unit_rr #(.NCH(2), .AW(32), .DW(32), .TMO(4)) dut (
    .CLK(CLK), .RST(RST), .ch_ren(ch_ren), .ch_wen(ch_wen), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_halt(ch_halt), .ch_busy(ch_busy), .ch_hit(ch_hit),
    .ch_err(ch_err), .ch_rdata(ch_rdata), .ch_halted(ch_halted),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_hit(mem_hit), .mem_rdata(mem_rdata),
    .tmo_flag(tmo_flag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  ren, wen;
    logic [31:0] a0, w0, a1;
    logic        mh;
    logic [31:0] mrd;
    logic [1:0]  eBusy, eHit;
    logic [31:0] eRdata;
    logic        eRen, eWen;
    logic [31:0] eAddr, eWdata;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t v(input logic [1:0] ren, wen, input logic [31:0] a0, w0, a1,
                             input logic mh, input logic [31:0] mrd,
                             input logic [1:0] eb, eh, input logic [31:0] erd,
                             input logic er, ew, input logic [31:0] ea, ewd);
    vec_t r;
    r.ren = ren; r.wen = wen; r.a0 = a0; r.w0 = w0; r.a1 = a1; r.mh = mh; r.mrd = mrd;
    r.eBusy = eb; r.eHit = eh; r.eRdata = erd; r.eRen = er; r.eWen = ew;
    r.eAddr = ea; r.eWdata = ewd;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] ren, wen, halt, input logic [31:0] a0, w0, a1,
                       input logic mh, input logic [31:0] mrd);
    ch_ren = ren; ch_wen = wen; ch_halt = halt;
    ch_addr = {a1, a0}; ch_wdata = {32'h0, w0};
    mem_hit = mh; mem_rdata = mrd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkAllZero(input string name);
    chk({name, " flags"}, {24'h0, ch_busy, ch_hit, ch_err, ch_halted}, 32'h0);
    chk({name, " rdata"}, ch_rdata, 32'h0);
    chk({name, " maddr"}, mem_addr, 32'h0);
    chk({name, " mwdata"}, mem_wdata, 32'h0);
    chk({name, " en/tmo"}, {29'h0, mem_ren, mem_wen, tmo_flag}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = v(2'b10, 2'b01, 'h10, 'h11, 'h20, 0, 0,           2'b11, 2'b00, 0,            0, 0, 'h00, 'h00);
    tbl[1]  = v(2'b10, 2'b01, 'h10, 'h11, 'h20, 0, 0,           2'b11, 2'b00, 0,            0, 1, 'h10, 'h11);
    tbl[2]  = v(2'b10, 2'b01, 'h10, 'h11, 'h20, 1, 'h5555,      2'b10, 2'b01, 0,            0, 0, 'h10, 'h11);
    tbl[3]  = v(2'b10, 2'b00, 'h10, 'h11, 'h20, 0, 0,           2'b10, 2'b00, 0,            1, 0, 'h20, 'h00);
    tbl[4]  = v(2'b10, 2'b00, 'h00, 'h00, 'h20, 1, 'h12345678,  2'b00, 2'b10, 'h12345678,   0, 0, 'h20, 'h00);
    tbl[5]  = v(2'b00, 2'b00, 'h00, 'h00, 'h00, 1, 'h9999,      2'b00, 2'b00, 0,            0, 0, 'h20, 'h00);
    tbl[6]  = v(2'b01, 2'b00, 'h40, 'h00, 'h00, 0, 0,           2'b01, 2'b00, 0,            0, 0, 'h20, 'h00);
    tbl[7]  = v(2'b01, 2'b00, 'h40, 'h00, 'h00, 0, 0,           2'b01, 2'b00, 0,            1, 0, 'h40, 'h00);
    tbl[8]  = v(2'b01, 2'b00, 'h40, 'h00, 'h00, 1, 'hDEADBEEF,  2'b00, 2'b01, 'hDEADBEEF,   0, 0, 'h40, 'h00);
    tbl[9]  = v(2'b00, 2'b00, 'h00, 'h00, 'h00, 0, 0,           2'b00, 2'b00, 0,            0, 0, 'h40, 'h00);
    tbl[10] = v(2'b10, 2'b01, 'h10, 'h11, 'h20, 0, 0,           2'b11, 2'b00, 0,            0, 0, 'h40, 'h00);
    tbl[11] = v(2'b10, 2'b01, 'h10, 'h11, 'h20, 0, 0,           2'b11, 2'b00, 0,            1, 0, 'h20, 'h00);
    tbl[12] = v(2'b10, 2'b01, 'h10, 'h11, 'h20, 1, 'hA5A5A5A5,  2'b01, 2'b10, 'hA5A5A5A5,   0, 0, 'h20, 'h00);
    tbl[13] = v(2'b00, 2'b01, 'h10, 'h11, 'h00, 0, 0,           2'b01, 2'b00, 0,            0, 1, 'h10, 'h11);
    tbl[14] = v(2'b00, 2'b01, 'h10, 'h11, 'h00, 1, 'h77,        2'b00, 2'b01, 0,            0, 0, 'h10, 'h11);
    tbl[15] = v(2'b00, 2'b00, 'h00, 'h00, 'h00, 0, 0,           2'b00, 2'b00, 0,            0, 0, 'h10, 'h11);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chkAllZero("reset");
    RST = 1'b0;

    // arbitration / single-read / repeat-contention vectors
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ren, tbl[i].wen, 2'b00, tbl[i].a0, tbl[i].w0, tbl[i].a1, tbl[i].mh, tbl[i].mrd);
      step();
      chk($sformatf("r%0d busy", i),   {30'h0, ch_busy}, {30'h0, tbl[i].eBusy});
      chk($sformatf("r%0d hit/err", i), {28'h0, ch_hit, ch_err}, {28'h0, tbl[i].eHit, 2'b00});
      chk($sformatf("r%0d rdata", i),  ch_rdata, tbl[i].eRdata);
      chk($sformatf("r%0d en", i),     {30'h0, mem_ren, mem_wen}, {30'h0, tbl[i].eRen, tbl[i].eWen});
      chk($sformatf("r%0d maddr", i),  mem_addr, tbl[i].eAddr);
      chk($sformatf("r%0d mwdata", i), mem_wdata, tbl[i].eWdata);
    end

    // timeout: no mem_hit, abort 4 cycles after mem_ren rises
    drive(2'b01, 0, 0, 'h30, 0, 0, 0, 0);
    step(); chk("tmo busy", {30'h0, ch_busy}, 32'h1);
    step(); chk("tmo grant", {mem_ren, mem_addr[30:0]}, {1'b1, 31'h30});
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("tmo wait%0d", k), {28'h0, ch_err, mem_ren, tmo_flag}, 32'h2);
    end
    step();
    chk("tmo err", {28'h0, ch_err, ch_hit}, 32'h4);
    chk("tmo flag/en/busy", {28'h0, tmo_flag, mem_ren, ch_busy}, 32'h8);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); chk("tmo sticky", {29'h0, ch_err, tmo_flag}, 32'h1);

    // hit in the 4th BUSY cycle beats the timeout
    drive(2'b01, 0, 0, 'h34, 0, 0, 0, 0);
    step(); step(); chk("late grant", mem_addr, 32'h34);
    step(); step(); step();
    drive(2'b01, 0, 0, 'h34, 0, 0, 1, 'hCAFE);
    step();
    chk("late hit", {28'h0, ch_hit, ch_err}, 32'h4);
    chk("late rdata", ch_rdata, 32'hCAFE);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // asynchronous reset while BUSY
    drive(2'b10, 0, 0, 0, 0, 'h60, 0, 0);
    step(); step(); chk("pre-rst grant", {mem_ren, mem_addr[30:0]}, {1'b1, 31'h60});
    #3 RST = 1'b1;
    #1 chkAllZero("rstMid");
    drive(0, 0, 0, 0, 0, 0, 1, 'h1234);
    @(negedge CLK); RST = 1'b0;
    step(); chkAllZero("postRst");
    drive(2'b11, 0, 0, 'h70, 0, 'h74, 0, 0);
    step(); chk("prio busy", {30'h0, ch_busy}, 32'h3);
    step(); chk("prio ch0", {mem_ren, mem_addr[30:0]}, {1'b1, 31'h70});
    drive(2'b11, 0, 0, 'h70, 0, 'h74, 1, 'h1);
    step(); chk("prio hit0", {ch_hit, ch_rdata[29:0]}, {2'b01, 30'h1});
    drive(2'b10, 0, 0, 0, 0, 'h74, 0, 0);
    step(); chk("prio ch1", {mem_ren, mem_addr[30:0]}, {1'b1, 31'h74});
    drive(2'b10, 0, 0, 0, 0, 'h74, 1, 'h2);
    step(); chk("prio hit1", {ch_hit, ch_rdata[29:0]}, {2'b10, 30'h2});
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // new request while pending must not disturb the latched address
    drive(0, 2'b01, 0, 'h90, 'h91, 0, 0, 0);
    step(); chk("pend busy", {30'h0, ch_busy}, 32'h1);
    step(); chk("pend grant", {mem_wen, mem_addr[30:0]}, {1'b1, 31'h90});
    chk("pend wdata", mem_wdata, 32'h91);
    drive(0, 0, 0, 'h80, 'h81, 0, 0, 0);
    step(); chk("pend hold1", mem_addr, 32'h90);
    drive(0, 2'b01, 0, 'h80, 'h81, 0, 0, 0);
    step(); chk("pend hold2", mem_addr, 32'h90);
    chk("pend hold wd", mem_wdata, 32'h91);
    drive(0, 2'b01, 0, 'h80, 'h81, 0, 1, 'h5);
    step(); chk("pend hit", {ch_hit, ch_rdata[29:0]}, {2'b01, 30'h0});
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); chk("pend clear", {30'h0, ch_busy}, 32'h0);

    // halt while ch1 is in flight: it still completes, then ch1 is locked out
    drive(2'b10, 0, 0, 0, 0, 'h50, 0, 0);
    step(); step(); chk("halt grant", {mem_ren, mem_addr[30:0]}, {1'b1, 31'h50});
    drive(2'b10, 0, 2'b10, 0, 0, 'h50, 0, 0);
    step(); chk("halt set", {28'h0, ch_halted, ch_busy}, 32'h a);
    drive(2'b10, 0, 0, 0, 0, 'h50, 1, 'hBEEF0001);
    step(); chk("halt hit", {28'h0, ch_hit, ch_busy}, 32'h8);
    chk("halt rdata", ch_rdata, 32'hBEEF0001);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(2'b10, 0, 0, 0, 0, 'h58, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("halt lock%0d", k), {28'h0, ch_halted, ch_busy}, 32'h8);
      chk($sformatf("halt idle%0d", k), {31'h0, mem_ren}, 32'h0);
    end
    drive(2'b01, 0, 2'b01, 'h5C, 0, 0, 0, 0);
    step(); chk("halt+req", {28'h0, ch_halted, ch_busy}, 32'hC);
    drive(2'b01, 0, 0, 'h5C, 0, 0, 0, 0);
    step(); chk("halt0 lock", {29'h0, ch_busy, mem_ren}, 32'h0);
    step(); chk("halt0 idle", {29'h0, ch_busy, mem_ren}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
